// File: rtl/gost_pkg.sv
// Shared widths, FSM states, Magma S-box tables and key schedule for the GOST block cores.
package gost_pkg;

    localparam int unsigned BLOCK_W = 64;
    localparam int unsigned HALF_W  = 32;
    localparam int unsigned KEY_W   = 256;
    localparam int unsigned ROUNDS  = 32;
    localparam int unsigned ROT     = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Entry k holds the sbox<k> table; value for input v sits at bits [4v+3:4v].
    localparam logic [63:0] SBOX [8] = '{
        64'h2BC96AF43850DE71,
        64'h73AD0B4FC19652E8,
        64'h0E34187BAC296FD5,
        64'hC24BE390D618A5F7,
        64'hB9E35A076F4D128C,
        64'h069C471EDAF2853B,
        64'hF0DB74E1C5A93286,
        64'h1F307D8E9B5A264C
    };

    // mode 1 = encrypt (K0..K7 three times, then K7..K0); mode 0 = decrypt (K0..K7, then reversed).
    function automatic logic [2:0] key_index(input logic [4:0] round, input logic mode);
        logic fwd;
        fwd = (round < 5'd8) || (mode && (round < 5'd24));
        return fwd ? round[2:0] : (3'd7 - round[2:0]);
    endfunction

endpackage

// File: rtl/gost_round_f.sv
// GOST round function f(A0, K) = rol11(S(A0 + K)), purely combinational.
module gost_round_f
    import gost_pkg::*;
(
    input  logic [HALF_W-1:0] a_i,
    input  logic [HALF_W-1:0] k_i,
    output logic [HALF_W-1:0] f_o
);

    logic [HALF_W-1:0] sum;
    logic [HALF_W-1:0] sub;

    assign sum = a_i + k_i;

    // Nibble n (counted from the LSB) goes through sbox(7-n).
    for (genvar n = 0; n < 8; n++) begin : g_sbox
        localparam logic [63:0] SBOX_ROW = SBOX[7-n];
        assign sub[4*n +: 4] = SBOX_ROW[{sum[4*n +: 4], 2'b00} +: 4];
    end

    assign f_o = {sub[HALF_W-ROT-1:0], sub[HALF_W-1:HALF_W-ROT]};

endmodule

// File: rtl/gost_decrypt_core.sv
// Iterative GOST 28147-89 / Magma block decryptor, one round per clock, valid/ready both sides.
// Define GOST_BIDIR_EN to add the MODE port (1 = encrypt, 0 = decrypt) latched at accept.
module gost_decrypt_core
    import gost_pkg::*;
#(
    parameter string SBOX_DIR = ""
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic [KEY_W-1:0]   KEY,
`ifdef GOST_BIDIR_EN
    input  logic               MODE,
`endif
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [BLOCK_W-1:0] DIN,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [BLOCK_W-1:0] DOUT
);

    // S-box contents are compiled in from gost_pkg; SBOX_DIR only names where they came from.
    if (SBOX_DIR != "") begin : g_sbox_dir
    end

    state_e             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [HALF_W-1:0]  a1_q, a1_d;
    logic [HALF_W-1:0]  a0_q, a0_d;
    logic [BLOCK_W-1:0] dout_q, dout_d;
    logic               out_valid_q, out_valid_d;
    logic               mode_sel;
    logic [HALF_W-1:0]  key_words [8];
    logic [HALF_W-1:0]  k_cur;
    logic [HALF_W-1:0]  f_out;

`ifdef GOST_BIDIR_EN
    logic mode_q, mode_d;

    always_comb begin
        mode_d = mode_q;
        if (state_q == IDLE && IN_VALID) begin
            mode_d = MODE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            mode_q <= 1'b0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign mode_sel = mode_q;
`else
    assign mode_sel = 1'b0;
`endif

    for (genvar i = 0; i < 8; i++) begin : g_key_words
        assign key_words[i] = key_q[KEY_W-1-HALF_W*i -: HALF_W];
    end

    assign k_cur = key_words[key_index(cnt_q, mode_sel)];

    gost_round_f u_round_f (
        .a_i (a0_q),
        .k_i (k_cur),
        .f_o (f_out)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        a1_d        = a1_q;
        a0_d        = a0_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    state_d = RUN;
                    cnt_d   = 5'd0;
                    key_d   = KEY;
                    a1_d    = DIN[BLOCK_W-1:HALF_W];
                    a0_d    = DIN[HALF_W-1:0];
                end
            end
            RUN: begin
                a1_d = a0_q;
                a0_d = a1_q ^ f_out;
                if (cnt_q == 5'(ROUNDS - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                // First DONE cycle registers the unswapped result; later cycles wait for the sink.
                if (!out_valid_q) begin
                    dout_d      = {a0_q, a1_q};
                    out_valid_d = 1'b1;
                end else if (OUT_READY) begin
                    out_valid_d = 1'b0;
                    cnt_d       = 5'd0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            key_q       <= '0;
            a1_q        <= '0;
            a0_q        <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            a1_q        <= a1_d;
            a0_q        <= a0_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = out_valid_q;
    assign DOUT      = dout_q;

endmodule

// File: tb/tb_gost_decrypt_core.sv
// Directed scoreboard bench for gost_decrypt_core; GOST_BIDIR_EN adds the encrypt/decrypt round trip.
module tb_gost_decrypt_core;

    localparam logic [255:0] MKEY =
        256'hffeeddccbbaa9988_7766554433221100_f0f1f2f3f4f5f6f7_f8f9fafbfcfdfeff;
    localparam logic [63:0] MPT = 64'hfedcba9876543210;
    localparam logic [63:0] MCT = 64'h4ee901e5c2d8ca3d;

    // Magma pi tables, pi_n[v] in natural order.
    localparam logic [3:0] PI [8][16] = '{
        '{4'hC, 4'h4, 4'h6, 4'h2, 4'hA, 4'h5, 4'hB, 4'h9, 4'hE, 4'h8, 4'hD, 4'h7, 4'h0, 4'h3, 4'hF, 4'h1},
        '{4'h6, 4'h8, 4'h2, 4'h3, 4'h9, 4'hA, 4'h5, 4'hC, 4'h1, 4'hE, 4'h4, 4'h7, 4'hB, 4'hD, 4'h0, 4'hF},
        '{4'hB, 4'h3, 4'h5, 4'h8, 4'h2, 4'hF, 4'hA, 4'hD, 4'hE, 4'h1, 4'h7, 4'h4, 4'hC, 4'h9, 4'h6, 4'h0},
        '{4'hC, 4'h8, 4'h2, 4'h1, 4'hD, 4'h4, 4'hF, 4'h6, 4'h7, 4'h0, 4'hA, 4'h5, 4'h3, 4'hE, 4'h9, 4'hB},
        '{4'h7, 4'hF, 4'h5, 4'hA, 4'h8, 4'h1, 4'h6, 4'hD, 4'h0, 4'h9, 4'h3, 4'hE, 4'hB, 4'h4, 4'h2, 4'hC},
        '{4'h5, 4'hD, 4'hF, 4'h6, 4'h9, 4'h2, 4'hC, 4'hA, 4'hB, 4'h7, 4'h8, 4'h1, 4'h4, 4'h3, 4'hE, 4'h0},
        '{4'h8, 4'hE, 4'h2, 4'h5, 4'h6, 4'h9, 4'h1, 4'hC, 4'hF, 4'h4, 4'hB, 4'h0, 4'hD, 4'hA, 4'h3, 4'h7},
        '{4'h1, 4'h7, 4'hE, 4'hD, 4'h0, 4'h5, 4'h8, 4'h3, 4'h4, 4'hF, 4'hA, 4'h6, 4'h9, 4'hC, 4'hB, 4'h2}
    };

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [255:0] KEY = '0;
    logic         IN_VALID = 1'b0;
    logic         IN_READY;
    logic [63:0]  DIN = '0;
    logic         OUT_VALID;
    logic         OUT_READY = 1'b0;
    logic [63:0]  DOUT;
`ifdef GOST_BIDIR_EN
    logic         MODE = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic [63:0] sb [$];

    gost_decrypt_core dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .KEY       (KEY),
`ifdef GOST_BIDIR_EN
        .MODE      (MODE),
`endif
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .DIN       (DIN),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DOUT      (DOUT)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] g_fn(input logic [31:0] a, input logic [31:0] k);
        logic [31:0] s;
        logic [31:0] t;
        s = a + k;
        t = '0;
        for (int n = 0; n < 8; n++) t[4*n +: 4] = PI[n][s[4*n +: 4]];
        return (t << 11) | (t >> 21);
    endfunction

    // Reference encryption (RFC 8891 formulation); the DUT decrypts its output back.
    function automatic logic [63:0] magma_enc(input logic [255:0] key, input logic [63:0] p);
        logic [31:0] a1, a0, tmp, k;
        int idx;
        a1 = p[63:32];
        a0 = p[31:0];
        for (int r = 0; r < 32; r++) begin
            idx = (r < 24) ? (r % 8) : (7 - (r % 8));
            k   = key[255 - 32*idx -: 32];
            tmp = a1 ^ g_fn(a0, k);
            a1  = a0;
            a0  = tmp;
        end
        return {a0, a1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a block, wait (bounded) for acceptance, push its expected result.
    task automatic send(input logic [63:0] din, input logic [63:0] exp, output int acc);
        int n;
        IN_VALID = 1'b1;
        DIN      = din;
        n = 0;
        while (!IN_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!IN_READY) begin
            chk("accept_timeout", 64'(IN_READY), 64'd1);
            acc = cyc;
        end else begin
            sb.push_back(exp);
            @(negedge CLK);
            acc = cyc;
        end
    endtask

    // Wait (bounded) for OUT_VALID, then check DOUT against the scoreboard and the latency.
    task automatic take(input string tag, input int acc);
        bit got;
        logic [63:0] exp;
        got = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_out_valid"}, 64'(got), 64'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        if (got) begin
            chk({tag, "_dout"}, DOUT, exp);
            chk({tag, "_latency"}, 64'(cyc - acc), 64'd33);
        end
    endtask

    initial begin
        int acc, acc2, vcyc, bad;
        logic [63:0] p, p2;

        repeat (3) @(negedge CLK);
        chk("rst_in_ready", 64'(IN_READY), 64'd1);
        chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_dout", DOUT, 64'd0);
        RST_N = 1'b1;
        KEY   = MKEY;
        @(negedge CLK);

        chk("model_vector", magma_enc(MKEY, MPT), MCT);

        // Standard vector, latency, then 20 cycles of backpressure with IN_VALID noise.
        OUT_READY = 1'b0;
        send(MCT, MPT, acc);
        IN_VALID = 1'b0;
        chk("run_in_ready", 64'(IN_READY), 64'd0);
        take("magma", acc);
        bad = 0;
        IN_VALID = 1'b1;
        DIN      = 64'h0123456789abcdef;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (DOUT !== MPT || OUT_VALID !== 1'b1 || IN_READY !== 1'b0) bad++;
        end
        chk("backpressure_hold", 64'(bad), 64'd0);
        IN_VALID  = 1'b0;
        OUT_READY = 1'b1;
        @(negedge CLK);
        chk("release_in_ready", 64'(IN_READY), 64'd1);
        chk("release_out_valid", 64'(OUT_VALID), 64'd0);

        // KEY cleared mid-run must not disturb the latched key.
        send(MCT, MPT, acc);
        IN_VALID = 1'b0;
        repeat (4) @(negedge CLK);
        KEY = '0;
        take("key_stable", acc);
        KEY = MKEY;

        // Reset around round 10 discards the block.
        send(MCT, MPT, acc);
        IN_VALID = 1'b0;
        repeat (10) @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        chk("midrst_in_ready", 64'(IN_READY), 64'd1);
        chk("midrst_out_valid", 64'(OUT_VALID), 64'd0);
        sb.delete();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b0) bad++;
        end
        chk("midrst_no_output", 64'(bad), 64'd0);
        p = {$urandom, $urandom};
        send(magma_enc(MKEY, p), p, acc);
        IN_VALID = 1'b0;
        take("after_rst", acc);

        // Back-to-back: IN_VALID stays high with the second block while the first runs.
        p  = {$urandom, $urandom};
        p2 = {$urandom, $urandom};
        send(magma_enc(MKEY, p), p, acc);
        DIN = magma_enc(MKEY, p2);
        take("b2b_first", acc);
        vcyc = cyc;
        send(magma_enc(MKEY, p2), p2, acc2);
        IN_VALID = 1'b0;
        chk("b2b_accept_gap", 64'(acc2 - vcyc), 64'd2);
        take("b2b_second", acc2);

        // Corner keys/blocks, then random ones.
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                KEY = '0;
                p   = '0;
            end else if (i == 1) begin
                KEY = '1;
                p   = '1;
            end else begin
                KEY = {$urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom};
                p   = {$urandom, $urandom};
            end
            send(magma_enc(KEY, p), p, acc);
            IN_VALID = 1'b0;
            take("pattern", acc);
        end

`ifdef GOST_BIDIR_EN
        KEY  = MKEY;
        MODE = 1'b1;
        send(MPT, MCT, acc);
        IN_VALID = 1'b0;
        MODE     = 1'b0;
        take("bidir_enc", acc);
        send(MCT, MPT, acc);
        IN_VALID = 1'b0;
        take("bidir_dec", acc);
`endif

        repeat (3) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
